sync_fifo_spram_banked: RTL and testbench
=========================================

# sync_fifo_spram_banked

Synchronous FIFO that stores its data in NBANK interleaved single-port RAM banks (sp_ram) rather than a dual-port array. Sustains one write and one read per cycle by steering each entry to bank (address mod NBANK) and parking a colliding write in a one-entry write buffer that drains on the next cycle. Adds programmable almost-full/almost-empty flags, a registered read-valid strobe, a held output register, and sticky overflow/underflow error flags. Drop-in successor for the two-bank FIFO in the same buffering layer.

## Interface
- DW, 16: data width.
- DEPTH, 16: number of entries; power of 2, multiple of NBANK, DEPTH >= 2*NBANK.
- NBANK, 2: number of sp_ram banks; power of 2, >= 2.
- AW, $clog2(DEPTH): pointer width; bank select = ptr[$clog2(NBANK)-1:0], bank address = ptr[AW-1:$clog2(NBANK)].
- AF_LVL, DEPTH-2: almost_full asserted when count >= AF_LVL.
- AE_LVL, 2: almost_empty asserted when count <= AE_LVL.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write request.
- din  in  DW  write data, sampled with wr_en.
- rd_en  in  1  read request.
- dout  out  DW  read data; updated one cycle after an accepted read, held otherwise.
- dout_valid  out  1  one-cycle pulse, dout carries new data.
- full / empty  out  1  count == DEPTH / count == 0.
- almost_full / almost_empty  out  1  threshold flags.
- fifo_cnt  out  AW+1  entries stored (includes a buffered write).
- overflow / underflow  out  1  sticky error flags.

## Operation
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; flags come from registered count only (no combinational fall-through).
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both; width AW+1, never wraps.
- wr_ptr/rd_ptr: AW bits, +1 on accept, wrap DEPTH-1 -> 0 naturally.
- Bank arbitration per cycle, priority: read > buffer drain > direct write.
  - Read: bank rd_ptr mod NBANK, ce=1, we=0.
  - Conflict = wr_acc & rd_acc & (wr bank == rd bank): din and wr_ptr captured in write buffer, buf_vld<=1.
  - Drain: when buf_vld, write buffered data to its bank this cycle, buf_vld<=0 unless a new conflict recaptures.
  - Direct write: wr_acc without conflict, write din to wr bank.
- Invariant (assert in bench): drain bank never equals current read bank or current direct-write bank; a read never targets the address held in the buffer. Follows from one-cycle drain and sequential pointers.
- Only one bank access per bank per cycle; idle banks ce=0.
- Read path: bank rdata is muxed by registered bank select into dout register on the cycle after rd_acc; dout_valid pulses that cycle; dout holds between reads.
- overflow set on wr_en & full; underflow set on rd_en & empty; both cleared only by rst.
- Reset: pointers, count, buf_vld, dout (0), dout_valid (0), overflow/underflow (0) cleared; empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LVL>0), fifo_cnt=0. RAM contents not cleared. Reset mid-operation discards buffered write and any pending read return (no dout_valid the cycle after rst).

## Timing
- Write-to-read: entry written in cycle t is readable (empty deasserts) in t+1; read data at dout in cycle of rd_acc+1.
- Throughput: 1 write + 1 read per cycle sustained indefinitely, any NBANK.
- Full with rd_en & wr_en: read accepted, write rejected, overflow set, count DEPTH-1.
- Empty with rd_en & wr_en: write accepted, read rejected, underflow set, count 1.
- Flags change on the clock edge after the accept that crosses the threshold.

## Test plan
- Reset then write 0x0001..0x0010 (DEPTH=16), no reads -> full=1 after 16th write, fifo_cnt=16, almost_full at count 14; 17th write sets overflow, count stays 16.
- Read 16 back-to-back -> dout 0x0001..0x0010 in order, one dout_valid per cycle starting 1 cycle after first rd_en; empty=1 after last; extra rd_en sets underflow.
- Prefill 4, then 200 cycles simultaneous rd_en/wr_en with incrementing data -> count stays 4, conflict buffer exercised every cycle (NBANK=2 and NBANK=4 builds), output sequence gap-free and in order.
- Random wr_en/rd_en 10k cycles against a reference queue, pointers wrapping many times -> dout/fifo_cnt/flags match model; bank-collision assertion never fires.
- Full with rd_en & wr_en simultaneous -> read data correct, count 15, overflow=1; empty with both -> count 1, underflow=1, no dout_valid.
- Assert rst while buf_vld=1 and a read pending -> next cycle all outputs at reset values, no dout_valid; subsequent write/read of 0xABCD returns 0xABCD.

Source files
------------

// File: rtl/sync_fifo_spram_banked.sv
// sync_fifo_spram_banked: synchronous FIFO whose storage is NBANK interleaved
// single-port RAM banks. Entry i lives in bank (i mod NBANK). A write that
// collides with a read on the same bank is parked for one cycle in a write
// buffer and drained on the following cycle, so one write and one read per
// cycle are sustained.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en, din          write request and data
//   rd_en               read request
//   dout, dout_valid    read data (held between reads) and one-cycle strobe
//   full, empty         count == DEPTH / count == 0
//   almost_full/empty   count >= AF_LVL / count <= AE_LVL
//   fifo_cnt            stored entries, including a buffered write
//   overflow/underflow  sticky error flags, cleared only by rst
module sync_fifo_spram_banked #(
  parameter int unsigned DW     = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NBANK  = 2,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   fifo_cnt,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned BW  = $clog2(NBANK);
  localparam int unsigned BAW = AW - BW;
  localparam int unsigned BD  = DEPTH / NBANK;
  localparam int unsigned CW  = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          buf_vld_q, buf_vld_d;
  logic [DW-1:0] buf_data_q, buf_data_d;
  logic [AW-1:0] buf_ptr_q, buf_ptr_d;
  logic          rd_vld_q, rd_vld_d;
  logic [BW-1:0] rd_bank_q, rd_bank_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;

  logic          wr_acc, rd_acc, conflict;
  logic [BW-1:0] wr_bank, rd_bank, buf_bank;

  logic [NBANK-1:0] bank_ce, bank_we;
  logic [BAW-1:0]   bank_addr  [NBANK];
  logic [DW-1:0]    bank_wdata [NBANK];
  logic [DW-1:0]    bank_rdata_q [NBANK];
  logic [DW-1:0]    mem [NBANK][BD];

  // Accept decisions and bank selection; flags come from registered state only.
  always_comb begin
    wr_acc   = wr_en & ~full_q;
    rd_acc   = rd_en & ~empty_q;
    wr_bank  = wr_ptr_q[BW-1:0];
    rd_bank  = rd_ptr_q[BW-1:0];
    buf_bank = buf_ptr_q[BW-1:0];
    conflict = wr_acc & rd_acc & (wr_bank == rd_bank);
  end

  // Per-bank port arbitration: read > buffer drain > direct write.
  // The drain never shares a bank with the read or direct write because the
  // pointers have both advanced by one since the conflict was captured.
  always_comb begin
    bank_ce = '0;
    bank_we = '0;
    for (int b = 0; b < NBANK; b++) begin
      bank_addr[b]  = '0;
      bank_wdata[b] = '0;
      if (rd_acc && rd_bank == BW'(b)) begin
        bank_ce[b]   = 1'b1;
        bank_addr[b] = rd_ptr_q[AW-1:BW];
      end else if (buf_vld_q && buf_bank == BW'(b)) begin
        bank_ce[b]    = 1'b1;
        bank_we[b]    = 1'b1;
        bank_addr[b]  = buf_ptr_q[AW-1:BW];
        bank_wdata[b] = buf_data_q;
      end else if (wr_acc && !conflict && wr_bank == BW'(b)) begin
        bank_ce[b]    = 1'b1;
        bank_we[b]    = 1'b1;
        bank_addr[b]  = wr_ptr_q[AW-1:BW];
        bank_wdata[b] = din;
      end
    end
  end

  // Next-state for pointers, count, write buffer, read return and flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d   = rd_ptr_q + AW'(rd_acc);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    buf_vld_d  = conflict;
    buf_data_d = conflict ? din : buf_data_q;
    buf_ptr_d  = conflict ? wr_ptr_q : buf_ptr_q;
    rd_vld_d   = rd_acc;
    rd_bank_d  = rd_acc ? rd_bank : rd_bank_q;
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    afull_d    = (count_d >= CW'(AF_LVL));
    aempty_d   = (count_d <= CW'(AE_LVL));
    ovf_d      = ovf_q | (wr_en & full_q);
    udf_d      = udf_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
      buf_ptr_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_bank_q  <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= (AF_LVL == 0);
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
      buf_ptr_q  <= buf_ptr_d;
      rd_vld_q   <= rd_vld_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Single-port RAM banks with synchronous read; read latches reset so dout is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++) bank_rdata_q[b] <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (bank_ce[b]) begin
          if (bank_we[b]) mem[b][bank_addr[b]] <= bank_wdata[b];
          else            bank_rdata_q[b]      <= mem[b][bank_addr[b]];
        end
      end
    end
  end

  // A bank's read latch only changes on a new read, so dout holds between reads.
  assign dout         = bank_rdata_q[rd_bank_q];
  assign dout_valid   = rd_vld_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign fifo_cnt     = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_spram_banked.sv
// Self-checking bench for sync_fifo_spram_banked against a queue reference model.
module tb_sync_fifo_spram_banked;

  localparam int unsigned DW     = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NBANK  = 2;
  localparam int unsigned AW     = 4;
  localparam int unsigned AF_LVL = DEPTH - 2;
  localparam int unsigned AE_LVL = 2;
  localparam int unsigned BW     = $clog2(NBANK);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   fifo_cnt;
  logic          overflow, underflow;

  sync_fifo_spram_banked #(
    .DW(DW), .DEPTH(DEPTH), .NBANK(NBANK), .AW(AW), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_cnt(fifo_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_vld = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check bank-usage invariant, advance, compare with model.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs = 1'b0);
    logic          rd_a, wr_a, conf;
    logic [AW-1:0] bp, rp, wp;
    logic [BW-1:0] bb, rb, wb;
    int            cnt;
    wr_en = w; rd_en = r; din = d; rst = rs;
    #1;
    if (!rs && dut.buf_vld_q) begin
      rd_a = r && (q.size() != 0);
      wr_a = w && (q.size() != DEPTH);
      bp = dut.buf_ptr_q; rp = dut.rd_ptr_q; wp = dut.wr_ptr_q;
      bb = bp[BW-1:0]; rb = rp[BW-1:0]; wb = wp[BW-1:0];
      conf = wr_a && rd_a && (wb == rb);
      if (rd_a) begin
        chk("drain_vs_read_bank", 32'(bb != rb), 32'd1);
        chk("read_vs_buf_addr", 32'(bp != rp), 32'd1);
      end
      if (wr_a && !conf) chk("drain_vs_write_bank", 32'(bb != wb), 32'd1);
    end
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      rd_a = r && (q.size() != 0);
      wr_a = w && (q.size() != DEPTH);
      if (w && q.size() == DEPTH) m_ovf = 1'b1;
      if (r && q.size() == 0)     m_udf = 1'b1;
      m_vld = 1'b0;
      if (rd_a) begin m_dout = q.pop_front(); m_vld = 1'b1; end
      if (wr_a) q.push_back(d);
    end
    cnt = q.size();
    chk("dout_valid",   32'(dout_valid),   32'(m_vld));
    chk("dout",         32'(dout),         32'(m_dout));
    chk("fifo_cnt",     32'(fifo_cnt),     32'(cnt));
    chk("full",         32'(full),         32'(cnt == DEPTH));
    chk("empty",        32'(empty),        32'(cnt == 0));
    chk("almost_full",  32'(almost_full),  32'(cnt >= AF_LVL));
    chk("almost_empty", 32'(almost_empty), 32'(cnt <= AE_LVL));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
  endtask

  initial begin
    logic [DW-1:0] data;
    int pw, pr;

    // Reset state
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0);

    // Fill 0x0001..0x0010, then an overflowing 17th write
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DW'(i));
    chk("full_after_16", 32'(fifo_cnt), 32'd16);
    step(1'b1, 1'b0, 16'h0011);
    chk("ovf_after_17", 32'(overflow), 32'd1);

    // Drain back-to-back, then an underflowing read
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
    chk("last_dout", 32'(dout), 32'h0010);
    step(1'b0, 1'b1, '0);
    chk("udf_after_extra", 32'(underflow), 32'd1);

    // Prefill 4, then 200 cycles of simultaneous read/write (conflict every cycle)
    step(1'b0, 1'b0, '0, 1'b1);
    data = 16'h0100;
    for (int i = 0; i < 4; i++) begin step(1'b1, 1'b0, data); data++; end
    for (int i = 0; i < 200; i++) begin step(1'b1, 1'b1, data); data++; end
    chk("stream_cnt", 32'(fifo_cnt), 32'd4);

    // Full with both requests, then empty with both requests
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(16'h2000 + i));
    step(1'b1, 1'b1, 16'h0055);
    chk("full_both_cnt", 32'(fifo_cnt), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 16'h0066);
    chk("empty_both_cnt", 32'(fifo_cnt), 32'd1);
    chk("empty_both_vld", 32'(dout_valid), 32'd0);

    // Reset with a buffered write and a read return pending
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 16'h1111);
    step(1'b1, 1'b0, 16'h2222);
    step(1'b1, 1'b1, 16'h3333);
    chk("buf_vld_before_rst", 32'(dut.buf_vld_q), 32'd1);
    step(1'b1, 1'b1, 16'h4444, 1'b1);
    step(1'b1, 1'b0, 16'hABCD);
    step(1'b0, 1'b1, '0);
    chk("abcd_return", 32'(dout), 32'h0000ABCD);

    // Random traffic with varying read/write pressure
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      case ((i / 500) % 4)
        0:       begin pw = 70; pr = 30; end
        1:       begin pw = 30; pr = 70; end
        2:       begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 90; end
      endcase
      step(32'($urandom_range(0, 99)) < pw, 32'($urandom_range(0, 99)) < pr, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
